// File: rtl/instr_pkg.sv
// Shared definitions for the instruction dispatch front end:
// opcodes, dispatcher FSM states and fetch channel indices.
package instr_pkg;

    localparam logic [7:0] OP_NOP      = 8'h00;
    localparam logic [7:0] OP_FETCH    = 8'h02;
    localparam logic [7:0] OP_FETCH1   = 8'h04;
    localparam logic [7:0] OP_CONV_CFG = 8'h81;
    localparam logic [7:0] OP_CONV_RUN = 8'h82;
    localparam logic [7:0] OP_SYNC     = 8'hF0;
    localparam logic [7:0] OP_HALT     = 8'hFF;

    localparam int CH_FEATURE = 0;
    localparam int CH_WEIGHT  = 1;
    localparam int CH_BIAS    = 2;
    localparam int CH_SCALER  = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_ISSUE_FETCH,
        S_CONV,
        S_WAIT_SYNC,
        S_HALT
    } state_e;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous instruction queue with registered full/empty flags.
// Ports: push/wdata in, pop in, rdata = head entry, full/empty flags.
module instr_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          do_push, do_pop;

    // A push into a full queue is accepted only alongside a pop.
    assign do_push = push && (!full_q || pop);
    assign do_pop  = pop && !empty_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
            2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
            default: cnt_d = cnt_q;
        endcase
        full_d  = (cnt_d == FULL_CNT);
        empty_d = (cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/instr_dispatch_unit.sv
// Instruction front end: queues instructions, decodes them and dispatches
// fetch commands (one-hot fetch_valid + payload) and conv config/start.
// Ports: instr valid/ready in, per-channel fetch valid/ready/done,
// conv cfg/start/done, status busy/halted/err_illegal.
module instr_dispatch_unit #(
    parameter int INSTR_W    = 64,
    parameter int FIFO_DEPTH = 8,
    parameter int NUM_CH     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic [NUM_CH-1:0]  fetch_valid,
    input  logic [NUM_CH-1:0]  fetch_ready,
    input  logic [NUM_CH-1:0]  fetch_done,
    output logic [7:0]         fetch_type,
    output logic [15:0]        src_addr,
    output logic [7:0]         dst_addr,
    output logic [7:0]         mem_sel,
    output logic [7:0]         fetch_count,
    output logic [2:0]         cfg_kernel_size,
    output logic [7:0]         cfg_feature_size,
    output logic               cfg_lb_enable,
    output logic               cfg_lb_mode,
    output logic               cfg_feat_in_sel,
    output logic               cfg_feat_out_sel,
    output logic               conv_start,
    input  logic               conv_done,
    output logic               busy,
    output logic               halted,
    output logic               err_illegal
);

    import instr_pkg::*;

    localparam logic [3:0] NUM_CH_L = 4'(NUM_CH);

    function automatic logic [7:0] fld(input logic [INSTR_W-1:0] w,
                                       input int k);
        return w[INSTR_W-1-8*k -: 8];
    endfunction

    state_e               state_q, state_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic [NUM_CH-1:0]    out_busy_q, out_busy_d;
    logic                 conv_busy_q, conv_busy_d;
    logic                 err_q, err_d;
    logic [2:0]           kern_q, kern_d;
    logic [7:0]           fsize_q, fsize_d;
    logic                 lb_en_q, lb_en_d;
    logic                 lb_mode_q, lb_mode_d;
    logic                 fin_q, fin_d;
    logic                 fout_q, fout_d;

    logic [INSTR_W-1:0]   head;
    logic                 fifo_full, fifo_empty, push, pop;
    logic [7:0]           head_op, head_f1, head_f2, head_f3;
    logic [7:0]           head_f4, head_f6;
    logic                 head_ch_bad;
    logic [7:0]           op_q, f1_q, f2_q, f3_q, f4_q, f5_q, f6_q, f7_q;
    logic [NUM_CH-1:0]    ch_sel;
    logic                 stall, issue, hs, more_work;
    logic                 unused_bits;

    assign push = instr_valid && !fifo_full;

    instr_fifo #(
        .W     (INSTR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (instr),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head_op = fld(head, 0);
    assign head_f1 = fld(head, 1);
    assign head_f2 = fld(head, 2);
    assign head_f3 = fld(head, 3);
    assign head_f4 = fld(head, 4);
    assign head_f6 = fld(head, 6);
    assign head_ch_bad = ({1'b0, head_f1[2:0]} >= NUM_CH_L);

    assign op_q = fld(instr_q, 0);
    assign f1_q = fld(instr_q, 1);
    assign f2_q = fld(instr_q, 2);
    assign f3_q = fld(instr_q, 3);
    assign f4_q = fld(instr_q, 4);
    assign f5_q = fld(instr_q, 5);
    assign f6_q = fld(instr_q, 6);
    assign f7_q = fld(instr_q, 7);

    assign unused_bits = ^{head, instr_q};

    always_comb begin
        ch_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_sel[i] = (f1_q[2:0] == 3'(i));
        end
    end

    assign stall = |(ch_sel & out_busy_q);
    assign issue = (state_q == S_ISSUE_FETCH) && !stall;
    assign hs    = |(fetch_valid & fetch_ready);

    // Going straight back to DECODE keeps fetches at one per 2 cycles.
    assign more_work = !fifo_empty || push;

    assign fetch_valid = issue ? ch_sel : '0;
    assign fetch_type  = issue ? f1_q : 8'h00;
    assign src_addr    = issue ? {f2_q, f3_q} : 16'h0000;
    assign dst_addr    = issue ? {f4_q[3:0], f5_q[3:0]} : 8'h00;
    assign mem_sel     = issue ? f6_q : 8'h00;
    assign fetch_count = !issue ? 8'h00 :
                         (op_q == OP_FETCH1) ? 8'h01 : f7_q;

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        // A new handshake outranks a coincident done on the same channel.
        out_busy_d = out_busy_q & ~fetch_done;
        conv_busy_d = conv_busy_q & ~conv_done;
        err_d      = err_q;
        kern_d     = kern_q;
        fsize_d    = fsize_q;
        lb_en_d    = lb_en_q;
        lb_mode_d  = lb_mode_q;
        fin_d      = fin_q;
        fout_d     = fout_q;
        pop        = 1'b0;
        conv_start = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (more_work) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (fifo_empty) begin
                    state_d = S_IDLE;
                end else begin
                    pop     = 1'b1;
                    instr_d = head;
                    state_d = S_IDLE;
                    unique case (head_op)
                        OP_NOP: ;
                        OP_FETCH, OP_FETCH1: begin
                            if (head_ch_bad) err_d = 1'b1;
                            else state_d = S_ISSUE_FETCH;
                        end
                        OP_CONV_CFG: begin
                            kern_d    = head_f3[2:0];
                            fsize_d   = head_f2;
                            lb_en_d   = head_f4[0];
                            lb_mode_d = head_f1[0];
                            fin_d     = head_f6[0];
                            fout_d    = head_f6[1];
                        end
                        OP_CONV_RUN: state_d = S_CONV;
                        OP_SYNC:     state_d = S_WAIT_SYNC;
                        OP_HALT:     state_d = S_HALT;
                        default:     err_d = 1'b1;
                    endcase
                end
            end
            S_ISSUE_FETCH: begin
                if (hs) begin
                    out_busy_d = out_busy_d | ch_sel;
                    state_d    = more_work ? S_DECODE : S_IDLE;
                end
            end
            S_CONV: begin
                if (out_busy_q == '0 && !conv_busy_q) begin
                    conv_start  = 1'b1;
                    conv_busy_d = 1'b1;
                    state_d     = more_work ? S_DECODE : S_IDLE;
                end
            end
            S_WAIT_SYNC: begin
                if (out_busy_q == '0 && !conv_busy_q) begin
                    state_d = more_work ? S_DECODE : S_IDLE;
                end
            end
            S_HALT: ;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            instr_q     <= '0;
            out_busy_q  <= '0;
            conv_busy_q <= 1'b0;
            err_q       <= 1'b0;
            kern_q      <= '0;
            fsize_q     <= '0;
            lb_en_q     <= 1'b0;
            lb_mode_q   <= 1'b0;
            fin_q       <= 1'b0;
            fout_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            out_busy_q  <= out_busy_d;
            conv_busy_q <= conv_busy_d;
            err_q       <= err_d;
            kern_q      <= kern_d;
            fsize_q     <= fsize_d;
            lb_en_q     <= lb_en_d;
            lb_mode_q   <= lb_mode_d;
            fin_q       <= fin_d;
            fout_q      <= fout_d;
        end
    end

    assign instr_ready      = !fifo_full;
    assign cfg_kernel_size  = kern_q;
    assign cfg_feature_size = fsize_q;
    assign cfg_lb_enable    = lb_en_q;
    assign cfg_lb_mode      = lb_mode_q;
    assign cfg_feat_in_sel  = fin_q;
    assign cfg_feat_out_sel = fout_q;
    assign halted           = (state_q == S_HALT);
    assign err_illegal      = err_q;
    assign busy = !fifo_empty || (state_q != S_IDLE) ||
                  (|out_busy_q) || conv_busy_q;

endmodule

// File: tb/tb_instr_dispatch_unit.sv
// Directed bench for instr_dispatch_unit: fetch dispatch, hazards,
// FIFO back-pressure, conv config/run, illegal opcodes, SYNC, HALT, reset.
module tb_instr_dispatch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [63:0] instr;
    logic [3:0]  fetch_valid;
    logic [3:0]  fetch_ready;
    logic [3:0]  fetch_done;
    logic [7:0]  fetch_type;
    logic [15:0] src_addr;
    logic [7:0]  dst_addr;
    logic [7:0]  mem_sel;
    logic [7:0]  fetch_count;
    logic [2:0]  cfg_kernel_size;
    logic [7:0]  cfg_feature_size;
    logic        cfg_lb_enable;
    logic        cfg_lb_mode;
    logic        cfg_feat_in_sel;
    logic        cfg_feat_out_sel;
    logic        conv_start;
    logic        conv_done;
    logic        busy;
    logic        halted;
    logic        err_illegal;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_dispatch_unit #(
        .INSTR_W    (64),
        .FIFO_DEPTH (8),
        .NUM_CH     (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .instr            (instr),
        .fetch_valid      (fetch_valid),
        .fetch_ready      (fetch_ready),
        .fetch_done       (fetch_done),
        .fetch_type       (fetch_type),
        .src_addr         (src_addr),
        .dst_addr         (dst_addr),
        .mem_sel          (mem_sel),
        .fetch_count      (fetch_count),
        .cfg_kernel_size  (cfg_kernel_size),
        .cfg_feature_size (cfg_feature_size),
        .cfg_lb_enable    (cfg_lb_enable),
        .cfg_lb_mode      (cfg_lb_mode),
        .cfg_feat_in_sel  (cfg_feat_in_sel),
        .cfg_feat_out_sel (cfg_feat_out_sel),
        .conv_start       (conv_start),
        .conv_done        (conv_done),
        .busy             (busy),
        .halted           (halted),
        .err_illegal      (err_illegal)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rdy"}, instr_ready, 1);
        chk({tag, "_fv"}, fetch_valid, 0);
        chk({tag, "_src"}, src_addr, 0);
        chk({tag, "_cnt"}, fetch_count, 0);
        chk({tag, "_cfg"}, {cfg_kernel_size, cfg_feature_size,
            cfg_lb_enable, cfg_lb_mode, cfg_feat_in_sel,
            cfg_feat_out_sel}, 0);
        chk({tag, "_cs"}, conv_start, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_halt"}, halted, 0);
        chk({tag, "_err"}, err_illegal, 0);
    endtask

    localparam logic [63:0] W_F1   = 64'h02_01_12_34_05_06_02_10;
    localparam logic [63:0] W_F0A  = 64'h02_00_AA_BB_01_02_00_04;
    localparam logic [63:0] W_F0B  = 64'h04_00_CC_DD_03_04_01_09;
    localparam logic [63:0] W_NOP  = 64'h00_00_00_00_00_00_00_00;
    localparam logic [63:0] W_CFG  = 64'h81_01_1C_03_01_00_02_00;
    localparam logic [63:0] W_RUN  = 64'h82_00_00_00_00_00_00_00;
    localparam logic [63:0] W_ILL  = 64'h37_00_00_00_00_00_00_00;
    localparam logic [63:0] W_F5   = 64'h02_05_11_22_00_00_00_01;
    localparam logic [63:0] W_SYNC = 64'hF0_00_00_00_00_00_00_00;
    localparam logic [63:0] W_HALT = 64'hFF_00_00_00_00_00_00_00;
    localparam logic [63:0] W_F2   = 64'h02_02_44_55_00_00_00_02;

    initial begin
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;
        fetch_ready = '0;
        fetch_done  = '0;
        conv_done   = 1'b0;

        tick();
        tick();
        #1;
        chk_reset_vals("reset");
        tick();
        rst = 1'b0;

        // FETCH on channel 1 with ready held low for 3 cycles
        tick();
        instr_valid = 1'b1;
        instr       = W_F1;
        #1;
        chk("f1_push_rdy", instr_ready, 1);
        tick();
        instr_valid = 1'b0;
        #1;
        chk("f1_decode_fv", fetch_valid, 0);
        chk("f1_decode_busy", busy, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            chk("f1_fv", fetch_valid, 4'b0010);
            chk("f1_src", src_addr, 16'h1234);
        end
        chk("f1_dst", dst_addr, 8'h56);
        chk("f1_msel", mem_sel, 8'h02);
        chk("f1_cnt", fetch_count, 8'h10);
        chk("f1_type", fetch_type, 8'h01);
        tick();
        fetch_ready = 4'b0010;
        #1;
        chk("f1_hs_fv", fetch_valid, 4'b0010);
        tick();
        fetch_ready = 4'b0000;
        #1;
        chk("f1_after_fv", fetch_valid, 0);
        chk("f1_after_src", src_addr, 0);
        chk("f1_after_busy", busy, 1);

        // Back-to-back fetches to channel 0: second waits for done
        tick();
        instr_valid = 1'b1;
        instr       = W_F0A;
        tick();
        instr       = W_F0B;
        tick();
        instr_valid = 1'b0;
        fetch_ready = 4'b0001;
        #1;
        chk("f0a_fv", fetch_valid, 4'b0001);
        chk("f0a_src", src_addr, 16'hAABB);
        tick();
        fetch_ready = 4'b0000;
        #1;
        chk("f0b_decode_fv", fetch_valid, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            #1;
            chk("f0b_stall_fv", fetch_valid, 0);
        end
        tick();
        fetch_done = 4'b0001;
        #1;
        chk("f0b_done_cyc_fv", fetch_valid, 0);
        tick();
        fetch_done = 4'b0000;
        #1;
        chk("f0b_fv", fetch_valid, 4'b0001);
        chk("f0b_cnt", fetch_count, 8'h01);
        chk("f0b_src", src_addr, 16'hCCDD);
        chk("f0b_dst", dst_addr, 8'h34);

        // Fill the FIFO with 8 NOPs while channel 0 is stalled on ready
        for (int i = 0; i < 8; i++) begin
            tick();
            instr_valid = 1'b1;
            instr       = W_NOP;
            #1;
            chk("fill_rdy", instr_ready, 1);
        end
        tick();
        instr_valid = 1'b0;
        #1;
        chk("full_rdy", instr_ready, 0);
        tick();
        #1;
        chk("full_rdy2", instr_ready, 0);
        tick();
        fetch_ready = 4'b0001;
        #1;
        chk("full_hs_fv", fetch_valid, 4'b0001);
        chk("full_hs_rdy", instr_ready, 0);
        tick();
        fetch_ready = 4'b0000;
        #1;
        chk("first_pop_rdy", instr_ready, 0);
        tick();
        #1;
        chk("after_pop_rdy", instr_ready, 1);
        repeat (20) tick();
        fetch_done = 4'b0001;
        tick();
        fetch_done = 4'b0000;

        // CONV_CFG then CONV_RUN while channel 1 is still busy
        tick();
        instr_valid = 1'b1;
        instr       = W_CFG;
        tick();
        instr       = W_RUN;
        tick();
        instr_valid = 1'b0;
        #1;
        chk("cfg_fsize", cfg_feature_size, 8'h1C);
        chk("cfg_kern", cfg_kernel_size, 3'd3);
        chk("cfg_fout", cfg_feat_out_sel, 1);
        chk("cfg_fin", cfg_feat_in_sel, 0);
        chk("cfg_lb", {cfg_lb_enable, cfg_lb_mode}, 2'b11);
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            chk("run_stall_cs", conv_start, 0);
        end
        tick();
        fetch_done = 4'b0010;
        #1;
        chk("run_done_cyc_cs", conv_start, 0);
        tick();
        fetch_done = 4'b0000;
        #1;
        chk("run_cs", conv_start, 1);
        tick();
        #1;
        chk("run_cs_pulse", conv_start, 0);
        chk("run_conv_busy", busy, 1);
        tick();
        conv_done = 1'b1;
        tick();
        conv_done = 1'b0;
        #1;
        chk("run_idle_busy", busy, 0);
        chk("cfg_hold", cfg_feature_size, 8'h1C);

        // Illegal opcode, out-of-range channel, then SYNC
        tick();
        instr_valid = 1'b1;
        instr       = W_ILL;
        tick();
        instr       = W_F5;
        tick();
        instr_valid = 1'b0;
        #1;
        chk("ill_err", err_illegal, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            chk("ill_fv", fetch_valid, 0);
        end
        chk("ill_err_sticky", err_illegal, 1);
        tick();
        instr_valid = 1'b1;
        instr       = W_SYNC;
        tick();
        instr_valid = 1'b0;
        tick();
        tick();
        #1;
        chk("sync_done_busy", busy, 0);
        chk("sync_err_sticky", err_illegal, 1);

        // HALT blocks further dispatch until reset
        tick();
        instr_valid = 1'b1;
        instr       = W_HALT;
        tick();
        instr       = W_F2;
        tick();
        instr_valid = 1'b0;
        #1;
        chk("halt_flag", halted, 1);
        tick();
        instr_valid = 1'b1;
        instr       = W_F2;
        tick();
        instr_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            chk("halt_fv", fetch_valid, 0);
        end
        chk("halt_hold", halted, 1);
        chk("halt_rdy", instr_ready, 1);
        chk("halt_busy", busy, 1);
        tick();
        rst = 1'b1;
        tick();
        #1;
        chk_reset_vals("rst2");
        rst = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
